// File: rtl/and_n_sweep_pkg.sv
// Shared types for the exhaustive AND-cell sweep controller.
// The sweep FSM state encoding is defined here.
package and_n_sweep_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/and_n_sweep_ctrl_sweep_settle_timer.sv
// Settle-window timer. Load it when a vector is driven, then count it down while settling.
// 'expired' marks the last settle cycle, so the window lasts exactly SETTLE_CYCLES cycles.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TW'(SETTLE_CYCLES);
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TW'(1));

endmodule

// File: rtl/and_n_sweep_ctrl.sv
// Exhaustive sweep sequencer and checker for one N-input AND cell.
// Define AND_N_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module and_n_sweep_ctrl
  import and_n_sweep_pkg::*;
#(
  parameter int INPUT_SIZE    = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int ERR_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [INPUT_SIZE-1:0] dut_a,
  input  logic                  dut_z,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  fail_valid,
  output logic [INPUT_SIZE-1:0] fail_vec
);

  if (INPUT_SIZE < 1) begin : g_bad_input_size
    $error("and_n_sweep_ctrl: INPUT_SIZE must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("and_n_sweep_ctrl: SETTLE_CYCLES must be >= 1");
  end

`ifdef AND_N_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_e                  state_q;
  logic [INPUT_SIZE:0]     vec_q;
  logic [INPUT_SIZE:0]     vec_d;
  logic [INPUT_SIZE-1:0]   dut_a_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [ERR_W-1:0]        err_q;
  logic [ERR_W-1:0]        err_d;
  logic                    fail_valid_q;
  logic [INPUT_SIZE-1:0]   fail_vec_q;
  logic                    expected;
  logic                    mismatch;
  logic                    finish_sweep;
  logic                    timer_expired;

  // The extra counter bit is the carry out of the last vector, which ends the sweep.
  assign vec_d        = vec_q + 1'b1;
  assign expected     = &dut_a_q;
  assign mismatch     = (dut_z !== expected);
  assign err_d        = (mismatch && (err_q != '1)) ? err_q + 1'b1 : err_q;
  assign finish_sweep = vec_d[INPUT_SIZE] || (STOP_ON_FAIL && mismatch);

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == DRIVE),
    .en     (state_q == SETTLE),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      dut_a_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            vec_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= DRIVE;
          end
        end
        DRIVE: begin
          dut_a_q <= vec_q[INPUT_SIZE-1:0];
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (timer_expired) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= dut_a_q;
          end
          vec_q <= vec_d;
          if (finish_sweep) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
            dut_a_q <= '0;
            state_q <= DONE;
          end else begin
            state_q <= DRIVE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_a      = dut_a_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_and_n_sweep_ctrl.sv
// Directed bench for and_n_sweep_ctrl (INPUT_SIZE=2, SETTLE_CYCLES=8) with a behavioural cell model.
// Define AND_N_SWEEP_STOP_ON_FAIL_EN here as well when the design is built with it.
module tb_and_n_sweep_ctrl;

  localparam int N  = 2;
  localparam int S  = 8;
  localparam int EW = 16;

`ifdef AND_N_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  dut_a;
  logic          dut_z;
  logic          busy;
  logic          dut_done;
  logic          pass;
  logic [EW-1:0] err_count;
  logic          fail_valid;
  logic [N-1:0]  fail_vec;

  int err_cnt = 0;
  int chk_cnt = 0;
  int mode    = 0;

  always #5 clk = ~clk;

  // Cell model: 0 = good AND, 1 = stuck-at-1, 2 = stuck-at-0.
  assign dut_z = (mode == 0) ? (&dut_a) : (mode == 1);

  and_n_sweep_ctrl #(
    .INPUT_SIZE   (N),
    .SETTLE_CYCLES(S),
    .ERR_W        (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_a     (dut_a),
    .dut_z     (dut_z),
    .busy      (busy),
    .done      (dut_done),
    .pass      (pass),
    .err_count (err_count),
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector v is driven at the end of cycle 10v+1 and held through cycle 10v+11; DONE (cycle 41) returns 0.
  function automatic logic [N-1:0] exp_a(input int n);
    if (n < 2 || n >= 41) return '0;
    return N'((n - 2) / 10);
  endfunction

  // Pulse start (cycle 0), then watch 60 cycles; n counts cycles after the start edge.
  task automatic sweep(input int m, input bit repulse, input bit full,
                       output int done_cyc, output int done_n);
    mode     = m;
    done_cyc = -1;
    done_n   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (repulse && n == 15);
      if (n == 1) begin
        check("pass_clr", pass, 0);
        check("err_clr", err_count, 0);
        check("busy_start", busy, 1);
      end
      if (full && n <= 41) check("dut_a", dut_a, exp_a(n));
      if (full && n == 40) check("busy_mid", busy, 1);
      if (full && n == 41) check("busy_done", busy, 0);
      if (dut_done) begin
        if (done_n == 0) done_cyc = n;
        done_n++;
      end
    end
    start = 1'b0;
    $display("sweep mode=%0d repulse=%0d done@%0d pulses=%0d err=%0d pass=%0d fail_vec=%0d",
             m, repulse, done_cyc, done_n, err_count, pass, fail_vec);
  endtask

  initial begin
    int dc;
    int dn;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", dut_done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fvalid", fail_valid, 0);
    check("rst_fvec", fail_vec, 0);
    check("rst_dut_a", dut_a, 0);
    reset = 1'b0;

    sweep(0, 1'b0, 1'b1, dc, dn);
    check("good_done_cyc", dc, 41);
    check("good_done_n", dn, 1);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_fvalid", fail_valid, 0);

    // Stuck-at-1 (follows a passing sweep, so pass_clr at n==1 is meaningful).
    sweep(1, 1'b0, !STOP, dc, dn);
    if (STOP) begin
      check("sa1_stop_done_cyc", dc, 11);
      check("sa1_stop_err", err_count, 1);
    end else begin
      check("sa1_done_cyc", dc, 41);
      check("sa1_err", err_count, 3);
    end
    check("sa1_fvalid", fail_valid, 1);
    check("sa1_fvec", fail_vec, 0);
    check("sa1_pass", pass, 0);
    check("sa1_dut_a", dut_a, 0);

    sweep(2, 1'b0, 1'b1, dc, dn);
    check("sa0_done_cyc", dc, 41);
    check("sa0_err", err_count, 1);
    check("sa0_fvalid", fail_valid, 1);
    check("sa0_fvec", fail_vec, 3);
    check("sa0_pass", pass, 0);
    check("sa0_dut_a", dut_a, 0);

    sweep(0, 1'b1, 1'b1, dc, dn);
    check("repulse_done_cyc", dc, 41);
    check("repulse_done_n", dn, 1);
    check("repulse_pass", pass, 1);

    // Reset while vector 2 is settling (cycle 25), then confirm nothing completes.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n < 25; n++) @(negedge clk);
    check("pre_rst_dut_a", dut_a, 2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dut_a", dut_a, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_pass", pass, 0);
    reset = 1'b0;
    dn = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dut_done) dn++;
    end
    check("mid_rst_no_done", dn, 0);
    $display("reset mid-sweep: done pulses after reset=%0d", dn);

    sweep(0, 1'b0, 1'b1, dc, dn);
    check("after_rst_done_cyc", dc, 41);
    check("after_rst_pass", pass, 1);
    check("after_rst_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
